// File: rtl/gemm_fetch_sched.sv
// rtl/gemm_fetch_sched.sv - paired data/weight FIFO fetch scheduler with credit-bounded output buffer
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, burst_len,        job start pulse (IDLE only) and job geometry,
//   burst_cnt                latched when a non-empty job is accepted
//   data_empty, weig_empty   FIFO empty flags
//   data_rd_en, weig_rd_en   lockstep FIFO read strobes (always equal)
//   data_dout/data_valid,    FIFO read return, valid one cycle after rd_en
//   weig_dout/weig_valid
//   pair_valid/pair_ready    output handshake for the buffer head
//   pair_data/pair_weig      head operand pair
//   pair_last                head is the final pair of a burst
//   busy, done, err          status: not idle, job-complete pulse, sticky lockstep error
module gemm_fetch_sched #(
  parameter int DW    = 32,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] burst_cnt,
  input  logic             data_empty,
  input  logic             weig_empty,
  output logic             data_rd_en,
  output logic             weig_rd_en,
  input  logic [DW-1:0]    data_dout,
  input  logic             data_valid,
  input  logic [DW-1:0]    weig_dout,
  input  logic             weig_valid,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [DW-1:0]    pair_data,
  output logic [DW-1:0]    pair_weig,
  output logic             pair_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]      OCC_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [AW+1:0]    DEPTH_W = (AW + 2)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [AW:0]      occ_q, occ_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic             infl_q, infl_d;
  logic             err_q, err_d;
  logic             zdone_q, zdone_d;

  logic [DW-1:0]    buf_data_q [DEPTH];
  logic [DW-1:0]    buf_weig_q [DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic [AW+1:0]    credit_sum;
  logic [CNT_W-1:0] len_m1;
  logic [CNT_W-1:0] cnt_m1;

  assign len_m1 = len_q - CNT_ONE;
  assign cnt_m1 = cnt_q - CNT_ONE;

  // Entries held plus the read still in flight; both count against the buffer
  // so a returning word always has a free slot.
  assign credit_sum = {1'b0, occ_q} + {{(AW + 1){1'b0}}, infl_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    burst_d = burst_q;
    ocnt_d  = ocnt_q;
    occ_d   = occ_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    err_d   = err_q;
    zdone_d = 1'b0;
    issue   = 1'b0;
    push    = 1'b0;

    pop = (occ_q != '0) & pair_ready;

    // Read return: both words must arrive together or the pair is dropped.
    if (infl_q) begin
      if (data_valid & weig_valid) begin
        push = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((burst_len != '0) && (burst_cnt != '0)) begin
            len_d   = burst_len;
            cnt_d   = burst_cnt;
            word_d  = '0;
            burst_d = '0;
            ocnt_d  = '0;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            // Empty job: acknowledge with a done pulse without touching the FIFOs.
            zdone_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        issue = ~data_empty & ~weig_empty & (credit_sum < DEPTH_W);
        if (issue) begin
          if (word_q == len_m1) begin
            word_d = '0;
            if (burst_q == cnt_m1) begin
              state_d = S_DRAIN;
            end else begin
              burst_d = burst_q + CNT_ONE;
            end
          end else begin
            word_d = word_q + CNT_ONE;
          end
        end
      end
      S_DRAIN: begin
        if ((occ_q == '0) && !infl_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    infl_d = issue;

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end

    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
      ocnt_d = (ocnt_q == len_m1) ? '0 : (ocnt_q + CNT_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      burst_q <= '0;
      ocnt_q  <= '0;
      occ_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      infl_q  <= 1'b0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      burst_q <= burst_d;
      ocnt_q  <= ocnt_d;
      occ_q   <= occ_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      infl_q  <= infl_d;
      err_q   <= err_d;
      zdone_q <= zdone_d;
    end
  end

  // Buffer storage carries no reset; contents are only observed while occ != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wptr_q] <= data_dout;
      buf_weig_q[wptr_q] <= weig_dout;
    end
  end

  assign data_rd_en = issue;
  assign weig_rd_en = issue;
  assign pair_valid = (occ_q != '0);
  assign pair_data  = buf_data_q[rptr_q];
  assign pair_weig  = buf_weig_q[rptr_q];
  assign pair_last  = pair_valid & (ocnt_q == len_m1);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) | zdone_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gemm_fetch_sched.sv
// tb/tb_gemm_fetch_sched.sv - directed bench for gemm_fetch_sched
module tb_gemm_fetch_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic [15:0] burst_cnt = '0;
  logic        data_empty, weig_empty;
  logic        data_rd_en, weig_rd_en;
  logic [31:0] data_dout = '0;
  logic        data_valid = 1'b0;
  logic [31:0] weig_dout = '0;
  logic        weig_valid = 1'b0;
  logic        pair_valid;
  logic        pair_ready = 1'b0;
  logic [31:0] pair_data, pair_weig;
  logic        pair_last, busy, done, err;

  gemm_fetch_sched #(.DW(32), .CNT_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .burst_len(burst_len), .burst_cnt(burst_cnt),
    .data_empty(data_empty), .weig_empty(weig_empty),
    .data_rd_en(data_rd_en), .weig_rd_en(weig_rd_en),
    .data_dout(data_dout), .data_valid(data_valid),
    .weig_dout(weig_dout), .weig_valid(weig_valid),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_data(pair_data), .pair_weig(pair_weig), .pair_last(pair_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // FIFO models
  logic [31:0] dmem [0:127];
  logic [31:0] wmem [0:127];
  int dwr = 0, wwr = 0, drd = 0, wrd = 0;
  int nreads = 0;
  int drop_at = -1;
  logic weig_hold = 1'b0;
  logic flush = 1'b0;

  assign data_empty = (drd == dwr);
  assign weig_empty = (wrd == wwr) | weig_hold;

  always @(posedge clk) begin
    if (flush) begin
      drd <= dwr;
      wrd <= wwr;
      data_valid <= 1'b0;
      weig_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      weig_valid <= 1'b0;
      if (data_rd_en && drd != dwr) begin
        data_dout  <= dmem[drd];
        data_valid <= 1'b1;
        drd <= drd + 1;
      end
      if (weig_rd_en && wrd != wwr) begin
        weig_dout  <= wmem[wrd];
        weig_valid <= (nreads != drop_at);
        wrd <= wrd + 1;
      end
      if (data_rd_en) nreads <= nreads + 1;
    end
  end

  // Monitors
  logic [31:0] got_d [0:127];
  logic [31:0] got_w [0:127];
  logic        got_l [0:127];
  int npop = 0, ndone = 0, nrd = 0, rd_bad = 0, hold_rd = 0, npush = 0;
  int cyc = 0, last_pop_cyc = 0, done_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pair_valid && pair_ready) begin
      got_d[npop] <= pair_data;
      got_w[npop] <= pair_weig;
      got_l[npop] <= pair_last;
      npop <= npop + 1;
      last_pop_cyc <= cyc;
    end
    if (done) begin
      ndone <= ndone + 1;
      done_cyc <= cyc;
    end
    if (data_rd_en) nrd <= nrd + 1;
    if (data_rd_en !== weig_rd_en) rd_bad <= rd_bad + 1;
    if (weig_hold && data_rd_en) hold_rd <= hold_rd + 1;
    if (data_valid && weig_valid) npush <= npush + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dval(input int t, input int i);
    return 32'hD000_0000 + 32'(t * 256 + i);
  endfunction

  function automatic logic [31:0] wval(input int t, input int i);
    return 32'hE000_0000 + 32'(t * 256 + i);
  endfunction

  task automatic load(input int n, input int t);
    for (int i = 0; i < n; i++) begin
      dmem[dwr] = dval(t, i);
      wmem[wwr] = wval(t, i);
      dwr++;
      wwr++;
    end
  endtask

  task automatic start_job(input int l, input int c);
    @(negedge clk);
    burst_len = 16'(l);
    burst_cnt = 16'(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n0;
    int k;
    n0 = ndone;
    k = 0;
    while (ndone == n0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(ndone != n0), 64'd1);
  endtask

  // Full 4x2 job with ready held high, checking order, last flags and done.
  task automatic run_t1(input string nm, input int t);
    int pb, db;
    pb = npop;
    db = ndone;
    load(8, t);
    pair_ready = 1'b1;
    start_job(4, 2);
    wait_done({nm, "_done"}, 200);
    chk({nm, "_done_width"}, 64'(done), 64'd0);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
    chk({nm, "_npop"}, 64'(npop - pb), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_data%0d", nm, i), 64'(got_d[pb + i]), 64'(dval(t, i)));
      chk($sformatf("%s_weig%0d", nm, i), 64'(got_w[pb + i]), 64'(wval(t, i)));
      chk($sformatf("%s_last%0d", nm, i), 64'(got_l[pb + i]), 64'((i % 4) == 3));
    end
    chk({nm, "_done_after_pop"}, 64'(done_cyc > last_pop_cyc), 64'd1);
    repeat (3) @(negedge clk);
    chk({nm, "_one_done"}, 64'(ndone - db), 64'd1);
    chk({nm, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int pb, db, rb, hb, nb, k;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_pair_valid", 64'(pair_valid), 64'd0);
    chk("rst_pair_last", 64'(pair_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_en", 64'(data_rd_en), 64'd0);

    // T1
    run_t1("t1", 1);

    // T2: len=3 cnt=1 with engine stalled
    pb = npop; rb = nrd; db = ndone;
    load(3, 2);
    pair_ready = 1'b0;
    start_job(3, 1);
    repeat (10) @(negedge clk);
    chk("t2_issued", 64'(nrd - rb), 64'd3);
    chk("t2_pair_valid", 64'(pair_valid), 64'd1);
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_rd_idle", 64'(data_rd_en), 64'd0);
    chk("t2_no_pop", 64'(npop - pb), 64'd0);
    chk("t2_no_done", 64'(ndone - db), 64'd0);
    pair_ready = 1'b1;
    wait_done("t2_done", 100);
    chk("t2_npop", 64'(npop - pb), 64'd3);
    chk("t2_data0", 64'(got_d[pb]), 64'(dval(2, 0)));
    chk("t2_last1", 64'(got_l[pb + 1]), 64'd0);
    chk("t2_last2", 64'(got_l[pb + 2]), 64'd1);

    // T2b: credit cap at DEPTH with a longer burst
    pb = npop; rb = nrd;
    load(6, 3);
    pair_ready = 1'b0;
    start_job(6, 1);
    repeat (12) @(negedge clk);
    chk("t2b_capped", 64'(nrd - rb), 64'd4);
    chk("t2b_rd_stall", 64'(data_rd_en), 64'd0);
    pair_ready = 1'b1;
    wait_done("t2b_done", 100);
    chk("t2b_npop", 64'(npop - pb), 64'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2b_data%0d", i), 64'(got_d[pb + i]), 64'(dval(3, i)));
    chk("t2b_last5", 64'(got_l[pb + 5]), 64'd1);

    // T3: weight FIFO empty mid-burst
    pb = npop;
    load(8, 4);
    pair_ready = 1'b1;
    start_job(4, 2);
    repeat (2) @(negedge clk);
    weig_hold = 1'b1;
    hb = hold_rd;
    repeat (10) @(negedge clk);
    chk("t3_busy_in_hold", 64'(busy), 64'd1);
    weig_hold = 1'b0;
    chk("t3_no_rd_in_hold", 64'(hold_rd - hb), 64'd0);
    wait_done("t3_done", 200);
    chk("t3_npop", 64'(npop - pb), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_data%0d", i), 64'(got_d[pb + i]), 64'(dval(4, i)));
    chk("t3_err", 64'(err), 64'd0);

    // T4: empty jobs
    rb = nrd; db = ndone;
    @(negedge clk);
    burst_len = 16'd0; burst_cnt = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4a_done", 64'(done), 64'd1);
    chk("t4a_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t4a_done_clear", 64'(done), 64'd0);
    burst_len = 16'd3; burst_cnt = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4b_done", 64'(done), 64'd1);
    chk("t4b_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    chk("t4_no_reads", 64'(nrd - rb), 64'd0);
    chk("t4_done_count", 64'(ndone - db), 64'd2);

    // T5: one read returns without weight valid
    pb = npop;
    load(8, 5);
    drop_at = nreads + 2;
    pair_ready = 1'b1;
    start_job(4, 2);
    wait_done("t5_done", 200);
    drop_at = -1;
    chk("t5_npop", 64'(npop - pb), 64'd7);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_data0", 64'(got_d[pb]), 64'(dval(5, 0)));
    chk("t5_data_skip", 64'(got_d[pb + 2]), 64'(dval(5, 3)));
    chk("t5_data_end", 64'(got_d[pb + 6]), 64'(dval(5, 7)));
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", 64'(err), 64'd1);

    // T6: reset in RUN with two pairs buffered
    load(8, 6);
    pair_ready = 1'b0;
    start_job(4, 2);
    chk("t6_err_cleared", 64'(err), 64'd0);
    nb = npush - 0;
    k = 0;
    nb = npush;
    while ((npush - nb) < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_occ2", 64'(npush - nb), 64'd2);
    chk("t6_valid_before", 64'(pair_valid), 64'd1);
    db = ndone;
    rst = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    chk("t6_pair_valid", 64'(pair_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    chk("t6_no_done", 64'(ndone - db), 64'd0);
    chk("t6_rd_idle", 64'(data_rd_en), 64'd0);

    run_t1("t6r", 7);

    chk("rd_lockstep", 64'(rd_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
